// File: rtl/operand_fetch_pkg.sv
// Shared Beta instruction definitions: data width, opcode constants, field positions
// and the OP/OPC class helpers used by operand fetch and the ALU.
package operand_fetch_pkg;

  localparam int unsigned DWIDTH = 32;
  localparam int unsigned IWIDTH = 32;
  localparam int unsigned OPW    = 6;

  // Instruction field positions (LSB of each field).
  localparam int unsigned OpcodeLsb = 26;
  localparam int unsigned RcLsb     = 21;
  localparam int unsigned RaLsb     = 16;
  localparam int unsigned RbLsb     = 11;
  localparam int unsigned LitLsb    = 0;

  localparam logic [OPW-1:0] OpAdd    = 6'h20;
  localparam logic [OPW-1:0] OpSub    = 6'h21;
  localparam logic [OPW-1:0] OpMul    = 6'h22;
  localparam logic [OPW-1:0] OpDiv    = 6'h23;
  localparam logic [OPW-1:0] OpCmpeq  = 6'h24;
  localparam logic [OPW-1:0] OpCmplt  = 6'h25;
  localparam logic [OPW-1:0] OpCmple  = 6'h26;
  localparam logic [OPW-1:0] OpAnd    = 6'h28;
  localparam logic [OPW-1:0] OpOr     = 6'h29;
  localparam logic [OPW-1:0] OpXor    = 6'h2A;
  localparam logic [OPW-1:0] OpXnor   = 6'h2B;
  localparam logic [OPW-1:0] OpShl    = 6'h2C;
  localparam logic [OPW-1:0] OpShr    = 6'h2D;
  localparam logic [OPW-1:0] OpSra    = 6'h2E;
  localparam logic [OPW-1:0] OpAddc   = 6'h30;
  localparam logic [OPW-1:0] OpSubc   = 6'h31;
  localparam logic [OPW-1:0] OpMulc   = 6'h32;
  localparam logic [OPW-1:0] OpDivc   = 6'h33;
  localparam logic [OPW-1:0] OpCmpeqc = 6'h34;
  localparam logic [OPW-1:0] OpCmpltc = 6'h35;
  localparam logic [OPW-1:0] OpCmplec = 6'h36;

  // Register-register ALU forms: 0x20-0x2E minus the 0x27 hole.
  function automatic logic is_op(input logic [OPW-1:0] op);
    return (op[5:4] == 2'b10) && (op[3:0] != 4'h7) && (op[3:0] != 4'hF);
  endfunction

  // Register-literal ALU forms: 0x30-0x3E minus the 0x37 hole.
  function automatic logic is_opc(input logic [OPW-1:0] op);
    return (op[5:4] == 2'b11) && (op[3:0] != 4'h7) && (op[3:0] != 4'hF);
  endfunction

endpackage

// File: rtl/operand_fetch_regfile_2r1w.sv
// Register file with two combinational read ports and one write port.
// The top register reads as zero and ignores writes.
module operand_fetch_regfile_2r1w
  import operand_fetch_pkg::*;
#(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned AWIDTH = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [AWIDTH-1:0] rd_a_addr_i,
  output logic [DWIDTH-1:0] rd_a_data_o,
  input  logic [AWIDTH-1:0] rd_b_addr_i,
  output logic [DWIDTH-1:0] rd_b_data_o,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i
);

  localparam logic [AWIDTH-1:0] ZeroReg = AWIDTH'(NREGS - 1);

  logic [DWIDTH-1:0] mem_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i && (wr_addr_i != ZeroReg)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_a_data_o = (rd_a_addr_i == ZeroReg) ? '0 : mem_q[rd_a_addr_i];
    rd_b_data_o = (rd_b_addr_i == ZeroReg) ? '0 : mem_q[rd_b_addr_i];
  end

endmodule

// File: rtl/operand_fetch.sv
// Beta register-read stage: decodes, reads/bypasses operands and hands a registered
// entry to execute over valid/ready, refreshing held operands from writeback.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned LITW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] in_instr,
  input  logic              wb_en,
  input  logic [AWIDTH-1:0] wb_addr,
  input  logic [DWIDTH-1:0] wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OPW-1:0]    ex_opcode,
  output logic [DWIDTH-1:0] ex_ra,
  output logic [DWIDTH-1:0] ex_rb,
  output logic [AWIDTH-1:0] ex_rc,
  output logic              ex_illegal
);

  localparam logic [AWIDTH-1:0] ZeroReg = AWIDTH'(NREGS - 1);

  logic [OPW-1:0]    dec_opcode;
  logic [AWIDTH-1:0] dec_rc, dec_ra, dec_rb;
  logic [LITW-1:0]   dec_lit;
  logic              dec_op, dec_opc, dec_legal;
  logic [DWIDTH-1:0] rf_ra, rf_rb, byp_ra, byp_rb, lit_sext;
  logic [DWIDTH-1:0] new_ra, new_rb;
  logic              accept;

  logic              valid_q, valid_d;
  logic [OPW-1:0]    opcode_q, opcode_d;
  logic [DWIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [AWIDTH-1:0] rc_q, rc_d;
  logic              illegal_q, illegal_d;
  // Source tags kept with the held entry so late writebacks can refresh it.
  logic [AWIDTH-1:0] ra_addr_q, ra_addr_d, rb_addr_q, rb_addr_d;
  logic              ra_used_q, ra_used_d, rb_is_reg_q, rb_is_reg_d;

  assign dec_opcode = in_instr[OpcodeLsb +: OPW];
  assign dec_rc     = in_instr[RcLsb +: AWIDTH];
  assign dec_ra     = in_instr[RaLsb +: AWIDTH];
  assign dec_rb     = in_instr[RbLsb +: AWIDTH];
  assign dec_lit    = in_instr[LitLsb +: LITW];
  assign dec_op     = is_op(dec_opcode);
  assign dec_opc    = is_opc(dec_opcode);
  assign dec_legal  = dec_op || dec_opc;
  assign lit_sext   = {{(DWIDTH - LITW){dec_lit[LITW-1]}}, dec_lit};

  operand_fetch_regfile_2r1w #(
    .NREGS (NREGS),
    .AWIDTH(AWIDTH)
  ) u_regfile (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rd_a_addr_i(dec_ra),
    .rd_a_data_o(rf_ra),
    .rd_b_addr_i(dec_rb),
    .rd_b_data_o(rf_rb),
    .wr_en_i    (wb_en),
    .wr_addr_i  (wb_addr),
    .wr_data_i  (wb_data)
  );

  assign in_ready = !valid_q || ex_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    byp_ra = (wb_en && (wb_addr == dec_ra) && (dec_ra != ZeroReg)) ? wb_data : rf_ra;
    byp_rb = (wb_en && (wb_addr == dec_rb) && (dec_rb != ZeroReg)) ? wb_data : rf_rb;
    new_ra = dec_legal ? byp_ra : '0;
    new_rb = dec_op ? byp_rb : (dec_opc ? lit_sext : '0);
  end

  always_comb begin
    valid_d     = valid_q;
    opcode_d    = opcode_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    rc_d        = rc_q;
    illegal_d   = illegal_q;
    ra_addr_d   = ra_addr_q;
    rb_addr_d   = rb_addr_q;
    ra_used_d   = ra_used_q;
    rb_is_reg_d = rb_is_reg_q;
    if (accept) begin
      valid_d     = 1'b1;
      opcode_d    = dec_opcode;
      ra_d        = new_ra;
      rb_d        = new_rb;
      rc_d        = dec_rc;
      illegal_d   = !dec_legal;
      ra_addr_d   = dec_ra;
      rb_addr_d   = dec_rb;
      ra_used_d   = dec_legal;
      rb_is_reg_d = dec_op;
    end else if (valid_q && ex_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Illegal entries never refresh, so their operands stay zero.
      if (wb_en && ra_used_q && (wb_addr == ra_addr_q) && (ra_addr_q != ZeroReg)) begin
        ra_d = wb_data;
      end
      if (wb_en && rb_is_reg_q && (wb_addr == rb_addr_q) && (rb_addr_q != ZeroReg)) begin
        rb_d = wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      opcode_q    <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      rc_q        <= '0;
      illegal_q   <= 1'b0;
      ra_addr_q   <= '0;
      rb_addr_q   <= '0;
      ra_used_q   <= 1'b0;
      rb_is_reg_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      opcode_q    <= opcode_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rc_q        <= rc_d;
      illegal_q   <= illegal_d;
      ra_addr_q   <= ra_addr_d;
      rb_addr_q   <= rb_addr_d;
      ra_used_q   <= ra_used_d;
      rb_is_reg_q <= rb_is_reg_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_opcode  = opcode_q;
  assign ex_ra      = ra_q;
  assign ex_rb      = rb_q;
  assign ex_rc      = rc_q;
  assign ex_illegal = illegal_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: decode classes, R31, bypass, held-operand refresh,
// back-pressure, back-to-back issue and reset while holding.
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_ra;
  logic [31:0] ex_rb;
  logic [4:0]  ex_rc;
  logic        ex_illegal;

  int tests_run;
  int tests_failed;

  operand_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_opcode (ex_opcode),
    .ex_ra     (ex_ra),
    .ex_rb     (ex_rb),
    .ex_rc     (ex_rc),
    .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr);
    in_valid = 1'b1; in_instr = instr;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; wb_en = 1'b0; wb_addr = '0;
    wb_data = '0; ex_ready = 1'b1;
    #12;
    tests_run++;
    if ({ex_valid, ex_opcode, ex_ra, ex_rb, ex_rc, ex_illegal} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b op=%h ra=%h rb=%h rc=%h ill=%b want all 0",
               ex_valid, ex_opcode, ex_ra, ex_rb, ex_rc, ex_illegal);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    ex_ready = 1'b1;
    issue(32'h8061_1000);
    tests_run++;
    if ({ex_valid, ex_opcode, ex_ra, ex_rb, ex_rc, ex_illegal} !==
        {1'b1, 6'h20, 32'd5, 32'd7, 5'd3, 1'b0}) begin
      tests_failed++;
      $display("FAIL add: got v=%b op=%h ra=%h rb=%h rc=%0d ill=%b want 1 20 5 7 3 0",
               ex_valid, ex_opcode, ex_ra, ex_rb, ex_rc, ex_illegal);
    end
    tick();
    tests_run++;
    if (ex_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_drain: ex_valid got %b want 0", ex_valid);
    end
  endtask

  task automatic test_addc();
    issue(32'hC061_FFFC);
    tests_run++;
    if ({ex_valid, ex_opcode, ex_ra, ex_rb, ex_rc, ex_illegal} !==
        {1'b1, 6'h30, 32'd5, 32'hFFFF_FFFC, 5'd3, 1'b0}) begin
      tests_failed++;
      $display("FAIL addc: got v=%b op=%h ra=%h rb=%h rc=%0d ill=%b want 1 30 5 fffffffc 3 0",
               ex_valid, ex_opcode, ex_ra, ex_rb, ex_rc, ex_illegal);
    end
    tick();
  endtask

  task automatic test_r31();
    wb_write(5'd31, 32'h1234);
    // ADD R31,R2,R5 with a same-cycle write to R31 that must not bypass.
    wb_en = 1'b1; wb_addr = 5'd31; wb_data = 32'h1234;
    issue(32'h80BF_1000);
    wb_en = 1'b0;
    tests_run++;
    if ({ex_ra, ex_rb, ex_rc} !== {32'd0, 32'd7, 5'd5}) begin
      tests_failed++;
      $display("FAIL r31_read: got ra=%h rb=%h rc=%0d want 0 7 5", ex_ra, ex_rb, ex_rc);
    end
    tick();
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd99;
    issue(32'h8481_1000);
    wb_en = 1'b0;
    tests_run++;
    if ({ex_opcode, ex_ra, ex_rb, ex_rc} !== {6'h21, 32'd5, 32'd99, 5'd4}) begin
      tests_failed++;
      $display("FAIL bypass_sub: got op=%h ra=%0d rb=%0d rc=%0d want 21 5 99 4",
               ex_opcode, ex_ra, ex_rb, ex_rc);
    end
    tick();
  endtask

  task automatic test_hold();
    ex_ready = 1'b0;
    issue(32'hA4C1_1000);
    tests_run++;
    if ({ex_valid, ex_ra, ex_rb, in_ready} !== {1'b1, 32'd5, 32'd99, 1'b0}) begin
      tests_failed++;
      $display("FAIL hold_load: got v=%b ra=%h rb=%h rdy=%b want 1 5 63 0",
               ex_valid, ex_ra, ex_rb, in_ready);
    end
    // New instruction offered while stalled must be ignored; R1 write refreshes ra.
    in_valid = 1'b1; in_instr = 32'h8061_1000;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hAA;
    tick();
    tests_run++;
    if ({ex_opcode, ex_ra, ex_rb, ex_rc, in_ready} !== {6'h29, 32'hAA, 32'd99, 5'd6, 1'b0})
    begin
      tests_failed++;
      $display("FAIL hold_refresh_ra: got op=%h ra=%h rb=%h rc=%0d rdy=%b want 29 aa 63 6 0",
               ex_opcode, ex_ra, ex_rb, ex_rc, in_ready);
    end
    in_valid = 1'b0;
    wb_addr = 5'd2; wb_data = 32'h55;
    tick();
    wb_en = 1'b0;
    tests_run++;
    if ({ex_ra, ex_rb} !== {32'hAA, 32'h55}) begin
      tests_failed++;
      $display("FAIL hold_refresh_rb: got ra=%h rb=%h want aa 55", ex_ra, ex_rb);
    end
    ex_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_release_ready: got %b want 1", in_ready);
    end
    tick();
    tests_run++;
    if (ex_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_consume_once: ex_valid got %b want 0", ex_valid);
    end
  endtask

  task automatic test_hold_literal();
    // ADDC R1,0x1000,R3: the literal overlaps the Rb field (=R2) but must not refresh.
    ex_ready = 1'b0;
    issue(32'hC061_1000);
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h77;
    tick();
    wb_en = 1'b0;
    tests_run++;
    if ({ex_ra, ex_rb} !== {32'hAA, 32'h1000}) begin
      tests_failed++;
      $display("FAIL hold_literal: got ra=%h rb=%h want aa 1000", ex_ra, ex_rb);
    end
    ex_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    ex_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h8061_1000;
    tick();
    tests_run++;
    if ({ex_valid, ex_opcode, ex_ra, ex_rb, ex_rc} !== {1'b1, 6'h20, 32'hAA, 32'h77, 5'd3})
    begin
      tests_failed++;
      $display("FAIL b2b_first: got v=%b op=%h ra=%h rb=%h rc=%0d want 1 20 aa 77 3",
               ex_valid, ex_opcode, ex_ra, ex_rb, ex_rc);
    end
    in_instr = 32'h8481_1000;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({ex_valid, ex_opcode, ex_rc} !== {1'b1, 6'h21, 5'd4}) begin
      tests_failed++;
      $display("FAIL b2b_second: got v=%b op=%h rc=%0d want 1 21 4",
               ex_valid, ex_opcode, ex_rc);
    end
    tick();
  endtask

  task automatic test_illegal_reset();
    ex_ready = 1'b0;
    issue(32'h9CE1_1000);
    tests_run++;
    if ({ex_valid, ex_opcode, ex_ra, ex_rb, ex_rc, ex_illegal} !==
        {1'b1, 6'h27, 32'd0, 32'd0, 5'd7, 1'b1}) begin
      tests_failed++;
      $display("FAIL illegal: got v=%b op=%h ra=%h rb=%h rc=%0d ill=%b want 1 27 0 0 7 1",
               ex_valid, ex_opcode, ex_ra, ex_rb, ex_rc, ex_illegal);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ex_valid, ex_opcode, ex_ra, ex_rb, ex_rc, ex_illegal} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_hold: got v=%b op=%h ra=%h rb=%h rc=%h ill=%b want all 0",
               ex_valid, ex_opcode, ex_ra, ex_rb, ex_rc, ex_illegal);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ex_ready = 1'b1;
    tick();
    issue(32'h8061_1000);
    tests_run++;
    if ({ex_valid, ex_ra, ex_rb} !== {1'b1, 32'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL rf_cleared: got v=%b ra=%h rb=%h want 1 0 0", ex_valid, ex_ra, ex_rb);
    end
    tick();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_add();
    test_addc();
    test_r31();
    test_bypass();
    test_hold();
    test_hold_literal();
    test_back_to_back();
    test_illegal_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
